// File: rtl/rmii_mii_bridge.sv
// RMII (50 MHz, dibit) to MII (nibble) bridge with runtime 10/100 selection,
// a preamble-aligned receive elastic FIFO and saturating frame/error counters.
module rmii_mii_bridge #(
  parameter int RXFIFO_DEPTH = 8,
  parameter int CNTW         = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            speed100,
  input  logic [1:0]      phy_RXD,
  input  logic            phy_CRS,
  output logic [3:0]      mac_RXD,
  output logic            mac_RX_DV,
  output logic            mac_RX_CLK,
  input  logic [3:0]      mac_TXD,
  input  logic            mac_TX_EN,
  output logic            mac_TX_CLK,
  output logic [1:0]      phy_TXD,
  output logic            phy_TX_EN,
  output logic [CNTW-1:0] rx_frames,
  output logic [CNTW-1:0] rx_odd,
  output logic [CNTW-1:0] rx_drop
);

  localparam int            AW       = $clog2(RXFIFO_DEPTH);
  localparam logic [AW:0]   HALF_LVL = (AW+1)'(RXFIFO_DEPTH / 2);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(RXFIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA} rx_state_t;

  // ---------------- shared MII clock divider and speed latch ----------------
  logic       speed_q;
  logic [3:0] div_cnt;
  logic       mac_clk;
  logic       tick, fall_tick, rise_tick;
  logic       fifo_empty;
  rx_state_t  state, state_d;

  assign tick       = speed_q || (div_cnt == 4'd9);
  assign fall_tick  = tick && mac_clk;
  assign rise_tick  = tick && !mac_clk;
  assign mac_RX_CLK = mac_clk;
  assign mac_TX_CLK = mac_clk;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process order never matters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      mac_clk <= 1'b0;
      speed_q <= 1'b1;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        mac_clk <= ~mac_clk;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
      // Rate only changes with both directions quiet, so no frame is split.
      if (state == RX_IDLE && fifo_empty && !mac_TX_EN && !phy_TX_EN)
        speed_q <= speed100;
    end
  end

  // ---------------- RX sampling phase ----------------
  logic       crs_prev;
  logic [3:0] rx_ph;
  logic       rephase, samp;

  assign rephase = !speed_q && (state == RX_IDLE) && phy_CRS && !crs_prev;
  assign samp    = speed_q || ((rx_ph == 4'd5) && !rephase);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crs_prev <= 1'b0;
      rx_ph    <= '0;
    end else begin
      crs_prev <= phy_CRS;
      if (rephase)            rx_ph <= 4'd1;
      else if (rx_ph == 4'd9) rx_ph <= '0;
      else                    rx_ph <= rx_ph + 4'd1;
    end
  end

  // ---------------- RX FSM ----------------
  logic       half, crs_lo, odd, pend_vld;
  logic [1:0] lo_dibit;
  logic [3:0] pend_nib;
  logic       lo_take, nib_done, frame_end;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    lo_take   = 1'b0;
    nib_done  = 1'b0;
    frame_end = 1'b0;
    if (samp) begin
      case (state)
        RX_IDLE:
          if (phy_CRS) begin
            if (phy_RXD == 2'b01) begin
              state_d = RX_DATA;
              lo_take = 1'b1;
            end else begin
              state_d = RX_PRE;
            end
          end
        RX_PRE:
          if (!phy_CRS) begin
            state_d = RX_IDLE;
          end else if (phy_RXD == 2'b01) begin
            state_d = RX_DATA;
            lo_take = 1'b1;
          end
        RX_DATA:
          if (!half) begin
            lo_take = 1'b1;
          end else if (!crs_lo && !phy_CRS) begin
            state_d   = RX_IDLE;
            frame_end = 1'b1;
          end else begin
            nib_done = 1'b1;
          end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Each nibble is staged one slot so the end of frame can still tag it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RX_IDLE;
      half     <= 1'b0;
      crs_lo   <= 1'b0;
      lo_dibit <= '0;
      pend_nib <= '0;
      pend_vld <= 1'b0;
      odd      <= 1'b0;
    end else begin
      state <= state_d;
      if (lo_take) begin
        lo_dibit <= phy_RXD;
        crs_lo   <= phy_CRS;
        half     <= 1'b1;
      end
      if (nib_done) begin
        half     <= 1'b0;
        pend_nib <= {phy_RXD, lo_dibit};
        pend_vld <= 1'b1;
        odd      <= ~odd;
      end
      if (frame_end) begin
        half     <= 1'b0;
        pend_vld <= 1'b0;
        odd      <= 1'b0;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [4:0]  mem [RXFIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count, tag_cnt;
  logic [4:0]  rd_ent;
  logic        wr_req, wr_en, drop, rd_go, rd_pop, rd_active, fifo_full;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_LVL);
  assign rd_ent     = mem[rd_ptr[AW-1:0]];
  assign rd_go      = rd_active || (count >= HALF_LVL) || (tag_cnt != '0);
  assign rd_pop     = fall_tick && rd_go && !fifo_empty;
  assign wr_req     = pend_vld && (nib_done || frame_end);
  assign wr_en      = wr_req && (!fifo_full || rd_pop);
  assign drop       = wr_req && fifo_full && !rd_pop;

  // NOTE: the storage array has no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {frame_end, pend_nib};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
      rd_active <= 1'b0;
      mac_RXD   <= '0;
      mac_RX_DV <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en && frame_end, rd_pop && rd_ent[4]})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (fall_tick) begin
        if (rd_pop) begin
          mac_RXD   <= rd_ent[3:0];
          mac_RX_DV <= 1'b1;
          rd_active <= !rd_ent[4];
        end else begin
          mac_RXD   <= '0;
          mac_RX_DV <= 1'b0;
        end
      end
    end
  end

  // ---------------- status counters ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_frames <= '0;
      rx_odd    <= '0;
      rx_drop   <= '0;
    end else begin
      if (frame_end && rx_frames != '1)        rx_frames <= rx_frames + 1'b1;
      if (frame_end && odd && rx_odd != '1)    rx_odd    <= rx_odd + 1'b1;
      if (drop && rx_drop != '1)               rx_drop   <= rx_drop + 1'b1;
    end
  end

  // ---------------- TX: nibble to dibit ----------------
  logic [3:0] tx_nib;
  logic       tx_en_q, fall_d, rise_d;

  // Low dibit launches one clk after capture, high dibit P clk later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_nib    <= '0;
      tx_en_q   <= 1'b0;
      fall_d    <= 1'b0;
      rise_d    <= 1'b0;
      phy_TXD   <= '0;
      phy_TX_EN <= 1'b0;
    end else begin
      fall_d <= fall_tick;
      rise_d <= rise_tick;
      if (fall_tick) begin
        tx_nib  <= mac_TXD;
        tx_en_q <= mac_TX_EN;
      end
      if (fall_d) begin
        phy_TXD   <= tx_en_q ? tx_nib[1:0] : 2'b00;
        phy_TX_EN <= tx_en_q;
      end else if (rise_d) begin
        phy_TXD   <= tx_en_q ? tx_nib[3:2] : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_rmii_mii_bridge.sv
// Directed bench for rmii_mii_bridge: RX frames at both rates, carrier toggle,
// odd-length frame, TX dibit sequence, deferred speed change, reset mid-frame.
`timescale 1ns/1ps
module tb_rmii_mii_bridge;
  localparam int DEPTH     = 8;
  localparam int CNTW      = 16;
  localparam int FRAME_NIB = 2 * (7 + 1 + 64);

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            speed100 = 1'b1;
  logic [1:0]      phy_RXD = 2'b00;
  logic            phy_CRS = 1'b0;
  logic [3:0]      mac_TXD = 4'h0;
  logic            mac_TX_EN = 1'b0;
  logic [3:0]      mac_RXD;
  logic            mac_RX_DV, mac_RX_CLK, mac_TX_CLK, phy_TX_EN;
  logic [1:0]      phy_TXD;
  logic [CNTW-1:0] rx_frames, rx_odd, rx_drop;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_odd = 0;
  int launch_viol = 0;
  logic [3:0] nibs [0:255];
  logic [3:0] rx_q [$];

  rmii_mii_bridge #(.RXFIFO_DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .resetn(resetn), .speed100(speed100),
    .phy_RXD(phy_RXD), .phy_CRS(phy_CRS),
    .mac_RXD(mac_RXD), .mac_RX_DV(mac_RX_DV), .mac_RX_CLK(mac_RX_CLK),
    .mac_TXD(mac_TXD), .mac_TX_EN(mac_TX_EN), .mac_TX_CLK(mac_TX_CLK),
    .phy_TXD(phy_TXD), .phy_TX_EN(phy_TX_EN),
    .rx_frames(rx_frames), .rx_odd(rx_odd), .rx_drop(rx_drop)
  );

  always #10 clk = ~clk;

  // The MAC samples receive data on the rising edge of its clock.
  always @(posedge mac_RX_CLK) if (mac_RX_DV === 1'b1) rx_q.push_back(mac_RXD);

  // Receive outputs may only move where the MII clock falls.
  logic [3:0] l_rxd = 4'h0;
  logic       l_dv = 1'b0, l_clk = 1'b0;
  always begin
    @(posedge clk); #1;
    if (resetn === 1'b1 && (mac_RXD !== l_rxd || mac_RX_DV !== l_dv) &&
        !(l_clk === 1'b1 && mac_RX_CLK === 1'b0))
      launch_viol++;
    l_rxd = mac_RXD;
    l_dv  = mac_RX_DV;
    l_clk = mac_RX_CLK;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input logic to, output bit ok);
    logic prev;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = mac_TX_CLK;
      step(1);
      if (prev !== to && mac_TX_CLK === to) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic mac_period(output int cyc);
    bit   ok;
    logic prev;
    wait_edge(1'b1, ok);
    cyc = ok ? 0 : -1;
    if (ok) begin
      for (int i = 0; i < 64; i++) begin
        prev = mac_RX_CLK;
        step(1);
        cyc++;
        if (prev === 1'b0 && mac_RX_CLK === 1'b1) break;
      end
    end
  endtask

  task automatic build_frame();
    logic [7:0] v;
    for (int i = 0; i < 15; i++) nibs[i] = 4'h5;
    nibs[15] = 4'hD;
    for (int b = 0; b < 120; b++) begin
      v = 8'(b * 7 + 3);
      nibs[16 + 2*b] = v[3:0];
      nibs[17 + 2*b] = v[7:4];
    end
  endtask

  task automatic drive_frame(input int nn, input int p, input bit toggle,
                             input int flip_at, input bit no_end);
    for (int i = 0; i < nn; i++) begin
      if (i == flip_at) speed100 = 1'b0;
      phy_CRS = !(toggle && i >= nn - 8);
      phy_RXD = nibs[i][1:0];
      step(p);
      phy_CRS = 1'b1;
      phy_RXD = nibs[i][3:2];
      step(p);
    end
    if (!no_end) begin
      phy_CRS = 1'b0;
      phy_RXD = 2'b00;
      step(2 * p);
    end
  endtask

  task automatic check_frame(input string name, input int nn, input int p);
    int bad;
    step(2 * p * (DEPTH + 6));
    checks++;
    if (rx_q.size() != nn) begin
      errors++;
      $display("FAIL %s_len: got %0d nibbles, expected %0d", name, rx_q.size(), nn);
    end
    bad = -1;
    for (int i = 0; i < nn && i < rx_q.size(); i++)
      if (bad < 0 && rx_q[i] !== nibs[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_data: nibble %0d got %h expected %h", name, bad, rx_q[bad], nibs[bad]);
    end
    checks++;
    if (rx_frames !== CNTW'(exp_frames)) begin
      errors++;
      $display("FAIL %s_frames: got %0d expected %0d", name, rx_frames, exp_frames);
    end
    checks++;
    if (rx_odd !== CNTW'(exp_odd)) begin
      errors++;
      $display("FAIL %s_odd: got %0d expected %0d", name, rx_odd, exp_odd);
    end
    checks++;
    if (rx_drop !== '0) begin
      errors++;
      $display("FAIL %s_drop: got %0d expected 0", name, rx_drop);
    end
    checks++;
    if (launch_viol != 0) begin
      errors++;
      $display("FAIL %s_launch: %0d off-edge output changes, expected 0", name, launch_viol);
    end
  endtask

  task automatic test_reset();
    int cyc;
    step(3);
    checks++;
    if ({mac_RXD, mac_RX_DV, mac_RX_CLK, mac_TX_CLK, phy_TXD, phy_TX_EN} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {mac_RXD, mac_RX_DV, mac_RX_CLK, mac_TX_CLK, phy_TXD, phy_TX_EN});
    end
    checks++;
    if ({rx_frames, rx_odd, rx_drop} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", rx_frames, rx_odd, rx_drop);
    end
    resetn = 1'b1;
    step(1);
    checks++;
    if (mac_TX_CLK !== 1'b1) begin
      errors++;
      $display("FAIL reset_divider_start: mac_TX_CLK got %b expected 1", mac_TX_CLK);
    end
    mac_period(cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL reset_speed100: period got %0d clk expected 2", cyc);
    end
  endtask

  task automatic test_rx_100();
    rx_q.delete();
    build_frame();
    drive_frame(FRAME_NIB, 1, 1'b0, -1, 1'b0);
    exp_frames++;
    check_frame("rx100", FRAME_NIB, 1);
  endtask

  task automatic test_carrier_toggle();
    rx_q.delete();
    drive_frame(FRAME_NIB, 1, 1'b1, -1, 1'b0);
    exp_frames++;
    check_frame("toggle", FRAME_NIB, 1);
  endtask

  task automatic test_odd();
    rx_q.delete();
    drive_frame(129, 1, 1'b0, -1, 1'b0);
    exp_frames++;
    exp_odd++;
    check_frame("odd", 129, 1);
  endtask

  task automatic test_tx();
    logic [3:0] seq [3];
    logic [1:0] exp_tx [6];
    logic [1:0] got [$];
    logic       prev;
    bit         ok;
    int         idx, txd_viol;
    seq = '{4'h5, 4'hD, 4'hA};
    exp_tx = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
    idx = 0;
    txd_viol = 0;
    wait_edge(1'b1, ok);
    mac_TX_EN = 1'b1;
    mac_TXD = seq[0];
    wait_edge(1'b0, ok);
    checks++;
    if (!ok || phy_TX_EN !== 1'b0) begin
      errors++;
      $display("FAIL tx_capture: edge_seen %0d phy_TX_EN %b expected edge and 0", ok, phy_TX_EN);
    end
    for (int i = 1; i <= 12; i++) begin
      prev = mac_TX_CLK;
      step(1);
      if (i == 1) begin
        checks++;
        if (phy_TX_EN !== 1'b1 || phy_TXD !== 2'b01) begin
          errors++;
          $display("FAIL tx_latency: got en=%b txd=%b expected en=1 txd=01", phy_TX_EN, phy_TXD);
        end
      end
      if (phy_TX_EN === 1'b1) got.push_back(phy_TXD);
      else if (phy_TXD !== 2'b00) txd_viol++;
      if (prev === 1'b0 && mac_TX_CLK === 1'b1) begin
        idx++;
        if (idx < 3) mac_TXD = seq[idx];
        else begin
          mac_TX_EN = 1'b0;
          mac_TXD = 4'h0;
        end
      end
    end
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL tx_en_len: got %0d dibits with phy_TX_EN=1, expected 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL tx_dibit%0d: got %b expected %b", i, got[i], exp_tx[i]);
      end
    end
    checks++;
    if (txd_viol != 0) begin
      errors++;
      $display("FAIL tx_idle_txd: %0d nonzero dibits while disabled, expected 0", txd_viol);
    end
  endtask

  task automatic test_speed_change();
    int cyc;
    rx_q.delete();
    drive_frame(40, 1, 1'b0, 10, 1'b0);
    exp_frames++;
    check_frame("speedchg", 40, 10);
    mac_period(cyc);
    checks++;
    if (cyc != 20) begin
      errors++;
      $display("FAIL speedchg_period: got %0d clk expected 20", cyc);
    end
  endtask

  task automatic test_rx_10();
    int cyc;
    rx_q.delete();
    drive_frame(FRAME_NIB, 10, 1'b0, -1, 1'b0);
    exp_frames++;
    check_frame("rx10", FRAME_NIB, 10);
    mac_period(cyc);
    checks++;
    if (cyc != 20) begin
      errors++;
      $display("FAIL rx10_period: got %0d clk expected 20", cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    speed100 = 1'b1;
    step(40);
    rx_q.delete();
    drive_frame(30, 1, 1'b0, -1, 1'b1);
    checks++;
    if (mac_RX_DV !== 1'b1) begin
      errors++;
      $display("FAIL midframe_active: mac_RX_DV got %b expected 1", mac_RX_DV);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({mac_RXD, mac_RX_DV, mac_RX_CLK, mac_TX_CLK, phy_TXD, phy_TX_EN} !== 10'd0) begin
      errors++;
      $display("FAIL midframe_outputs: got %b expected 0",
               {mac_RXD, mac_RX_DV, mac_RX_CLK, mac_TX_CLK, phy_TXD, phy_TX_EN});
    end
    phy_CRS = 1'b0;
    phy_RXD = 2'b00;
    step(3);
    resetn = 1'b1;
    step(20);
    checks++;
    if (rx_frames !== '0) begin
      errors++;
      $display("FAIL midframe_frames: got %0d expected 0", rx_frames);
    end
    mac_period(cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL midframe_speed: period got %0d clk expected 2", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_rx_100();
    test_carrier_toggle();
    test_odd();
    test_tx();
    test_speed_change();
    test_rx_10();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
